// File: rtl/babbage_arb_if.sv
// Handshake, length, abort and coefficient-config bundle for babbage_arb.
// The master side (requesters and sink) drives requests, config and out_ready; the slave side is the arbiter.
interface babbage_arb_if;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned LEN_W  = 5;

  logic [1:0]        req;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              abort;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [1:0]        gnt;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_id;
  logic              out_last;

  modport master (
    output req, len0, len1, abort, cfg_we, cfg_addr, cfg_wdata, out_ready,
    input  gnt, busy, out_valid, out_data, out_id, out_last
  );

  modport slave (
    input  req, len0, len1, abort, cfg_we, cfg_addr, cfg_wdata, out_ready,
    output gnt, busy, out_valid, out_data, out_id, out_last
  );
endinterface

// File: rtl/babbage_arb.sv
// Two-requester round-robin arbiter that streams difference-engine terms (cubic via h/f/g/D)
// for the granted requester, one term per STEP+EMIT pair, with valid/ready output handshake.
module babbage_arb (
  input  logic         clk,
  input  logic         rst,
  babbage_arb_if.slave bus
);
  localparam int unsigned DATA_W = 10;
  localparam int unsigned LEN_W  = 5;

  typedef enum logic [1:0] {IDLE, LOAD, STEP, EMIT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic                served_q, served_d;
  logic [DATA_W-1:0]   h_q, h_d, f_q, f_d, g_q, g_d;
  logic [DATA_W-1:0]   h0_q, h0_d, f0_q, f0_d, g0_q, g0_d, dc_q, dc_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                win_c;
  logic [LEN_W-1:0]    load_len_c;

  // State and datapath registers; reset leaves requester 0 favoured on a tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      id_q     <= 1'b0;
      last_q   <= 1'b0;
      served_q <= 1'b1;
      h_q      <= '0;
      f_q      <= '0;
      g_q      <= '0;
      rem_q    <= '0;
      h0_q     <= DATA_W'(1);
      f0_q     <= DATA_W'(5);
      g0_q     <= DATA_W'(10);
      dc_q     <= DATA_W'(6);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      last_q   <= last_d;
      served_q <= served_d;
      h_q      <= h_d;
      f_q      <= f_d;
      g_q      <= g_d;
      rem_q    <= rem_d;
      h0_q     <= h0_d;
      f0_q     <= f0_d;
      g0_q     <= g0_d;
      dc_q     <= dc_d;
    end
  end

  // Next-state and next-output logic; abort overrides every non-idle transition
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    valid_d    = 1'b0;
    id_d       = id_q;
    last_d     = last_q;
    served_d   = served_q;
    h_d        = h_q;
    f_d        = f_q;
    g_d        = g_q;
    rem_d      = rem_q;
    h0_d       = h0_q;
    f0_d       = f0_q;
    g0_d       = g0_q;
    dc_d       = dc_q;
    win_c      = (bus.req == 2'b11) ? ~served_q : bus.req[1];
    load_len_c = gnt_q[1] ? bus.len1 : bus.len0;

    if (bus.abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      gnt_d    = 2'b00;
      served_d = gnt_q[1];
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_we) begin
            case (bus.cfg_addr)
              2'd0:    h0_d = bus.cfg_wdata;
              2'd1:    f0_d = bus.cfg_wdata;
              2'd2:    g0_d = bus.cfg_wdata;
              default: dc_d = bus.cfg_wdata;
            endcase
          end
          if (bus.req != 2'b00) begin
            gnt_d   = win_c ? 2'b10 : 2'b01;
            state_d = LOAD;
          end
        end
        LOAD: begin
          h_d   = h0_q;
          f_d   = f0_q;
          g_d   = g0_q;
          rem_d = load_len_c;
          id_d  = gnt_q[1];
          if (load_len_c == '0) begin
            state_d  = IDLE;
            gnt_d    = 2'b00;
            served_d = gnt_q[1];
          end else begin
            state_d = STEP;
          end
        end
        STEP: begin
          h_d     = h_q + f_q;
          f_d     = f_q + g_q;
          g_d     = g_q + dc_q;
          rem_d   = rem_q - LEN_W'(1);
          last_d  = (rem_q == LEN_W'(1));
          valid_d = 1'b1;
          state_d = EMIT;
        end
        EMIT: begin
          valid_d = 1'b1;
          if (bus.out_ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              state_d  = IDLE;
              gnt_d    = 2'b00;
              served_d = gnt_q[1];
            end else begin
              state_d = STEP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = h_q;
  assign bus.out_id    = id_q;
  assign bus.out_last  = last_q;
endmodule
